// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// Memory-stage store path. Takes store requests from execute and turns the
// byte address, rs2 data and funct3 into a word-aligned write word plus byte
// enables. It decodes the target region (DMEM, IMEM, both, IO or unmapped) and
// drains stores in program order through a small FIFO. DMEM/IMEM writes take
// one cycle. IO writes use a valid/ready handshake, so a slow IO sink stalls
// only this buffer and not the pipeline.
//
// Optional feature macro: STORE_BYPASS_EN
//   When defined, a legal DMEM/IMEM store that arrives while the buffer is
//   empty is written in the same cycle and is not enqueued.
//   When undefined (default), every store goes through the buffer.
//
// Parameters
//   DEPTH   store buffer entries (power of two, 2..16)
//   MEM_AW  word-address width of DMEM/IMEM
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   store request handshake (in_ready == !full)
//   in_addr/in_data     byte address and unaligned rs2 data
//   in_funct3           0=SB, 1=SH, 2=SW, others rejected
//   dmem_we/imem_we     byte write enables of DMEM/IMEM
//   mem_addr/mem_wdata  shared word address / aligned write data
//   io_valid/io_ready   IO write handshake
//   io_addr/io_wstrb    IO word-aligned byte address and byte enables
//   empty               no stores buffered
//   misalign_err        one-cycle pulse for each rejected store
// -----------------------------------------------------------------------------
module store_unit #(
    parameter int DEPTH  = 4,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    input  logic [2:0]        in_funct3,
    output logic [3:0]        dmem_we,
    output logic [3:0]        imem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              io_valid,
    input  logic              io_ready,
    output logic [31:0]       io_addr,
    output logic [3:0]        io_wstrb,
    output logic              empty,
    output logic              misalign_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_DMEM,
        RGN_IMEM,
        RGN_BOTH,
        RGN_IO
    } region_t;

    typedef struct packed {
        logic [MEM_AW-1:0] waddr;
        logic [31:0]       addr;
        region_t           region;
        logic [31:0]       data;
        logic [3:0]        wstrb;
    } entry_t;

    entry_t            fifo [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    entry_t            new_entry;
    entry_t            head;
    logic              illegal;
    logic              accept;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              full;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    // in_ready comes only from the occupancy register, never from io_ready.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign head     = fifo[rd_ptr];

    // Request decode: region, lane steering and legality.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        new_entry       = '0;
        illegal         = 1'b0;
        new_entry.waddr = in_addr[MEM_AW+1:2];
        new_entry.addr  = {in_addr[31:2], 2'b00};

        case (in_addr[31:28])
            4'h1:    new_entry.region = RGN_DMEM;
            4'h2:    new_entry.region = RGN_IMEM;
            4'h3:    new_entry.region = RGN_BOTH;
            4'h8:    new_entry.region = RGN_IO;
            default: new_entry.region = RGN_NONE;
        endcase

        case (in_funct3)
            3'd0: begin
                new_entry.wstrb = 4'b0001 << in_addr[1:0];
                new_entry.data  = {4{in_data[7:0]}};
            end
            3'd1: begin
                new_entry.wstrb = 4'b0011 << in_addr[1:0];
                new_entry.data  = {2{in_data[15:0]}};
                illegal         = in_addr[0];
            end
            3'd2: begin
                new_entry.wstrb = 4'b1111;
                new_entry.data  = in_data;
                illegal         = (in_addr[1:0] != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef STORE_BYPASS_EN
    // Only an empty buffer may be bypassed, which keeps program order intact.
    assign bypass = accept && !illegal && empty &&
                    (new_entry.region == RGN_DMEM || new_entry.region == RGN_IMEM ||
                     new_entry.region == RGN_BOTH);
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !illegal && !bypass;

    // Drain logic: combinational from the head entry. An IO head holds the
    // FIFO until io_ready, which also keeps the IO outputs stable.
    always_comb begin
        dmem_we   = '0;
        imem_we   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        io_valid  = 1'b0;
        io_addr   = '0;
        io_wstrb  = '0;
        pop       = 1'b0;

        if (!empty) begin
            mem_addr  = head.waddr;
            mem_wdata = head.data;
            case (head.region)
                RGN_DMEM: dmem_we = head.wstrb;
                RGN_IMEM: imem_we = head.wstrb;
                RGN_BOTH: begin
                    dmem_we = head.wstrb;
                    imem_we = head.wstrb;
                end
                RGN_IO: begin
                    io_valid = 1'b1;
                    io_addr  = head.addr;
                    io_wstrb = head.wstrb;
                end
                default: ;  // unmapped: popped with no write
            endcase
            pop = (head.region != RGN_IO) || io_ready;
        end else if (bypass) begin
            mem_addr  = new_entry.waddr;
            mem_wdata = new_entry.data;
            if (new_entry.region == RGN_DMEM || new_entry.region == RGN_BOTH)
                dmem_we = new_entry.wstrb;
            if (new_entry.region == RGN_IMEM || new_entry.region == RGN_BOTH)
                imem_we = new_entry.wstrb;
        end
    end

    // Control state: pointers, occupancy and the reject pulse.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= accept && illegal;
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: the storage array is deliberately not reset; entries are only
    // visible through the occupancy count, which is reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= new_entry;
    end

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Self-checking bench for store_unit (default build, bypass disabled).
// A queue-based model tracks buffered stores; a compare process checks every
// output on each falling edge, and directed sequences pin literal values.
// -----------------------------------------------------------------------------
module tb_store_unit;

    localparam int DEPTH  = 4;
    localparam int MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_addr;
    logic [31:0]       in_data;
    logic [2:0]        in_funct3;
    logic [3:0]        dmem_we;
    logic [3:0]        imem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              io_valid;
    logic              io_ready;
    logic [31:0]       io_addr;
    logic [3:0]        io_wstrb;
    logic              empty;
    logic              misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_unit #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .in_funct3    (in_funct3),
        .dmem_we      (dmem_we),
        .imem_we      (imem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .io_valid     (io_valid),
        .io_ready     (io_ready),
        .io_addr      (io_addr),
        .io_wstrb     (io_wstrb),
        .empty        (empty),
        .misalign_err (misalign_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]  nib;    // region nibble in_addr[31:28]
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } st_t;

    st_t q[$];
    bit  exp_mis = 0;
    bit  started = 0;

    function automatic int access_size(input logic [2:0] f3);
        if (f3 == 3'd0) return 1;
        if (f3 == 3'd1) return 2;
        if (f3 == 3'd2) return 4;
        return 0;
    endfunction

    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] f3);
        int sz = access_size(f3);
        return (sz != 0) && ((int'(a[1:0]) % sz) == 0);
    endfunction

    // Store of sz bytes at offset off: lanes off..off+sz-1 enabled, each lane i
    // carries source byte (i mod sz) so the replicated pattern is reproduced.
    function automatic st_t make_store(input logic [31:0] a, input logic [31:0] d,
                                       input logic [2:0] f3);
        st_t s;
        int  sz  = access_size(f3);
        int  off = int'(a[1:0]);
        s.nib  = a[31:28];
        s.addr = a;
        s.data = '0;
        s.strb = '0;
        for (int i = 0; i < 4; i++) begin
            s.data[8*i +: 8] = d[8*(i % sz) +: 8];
            s.strb[i]        = (i >= off) && (i < off + sz);
        end
        return s;
    endfunction

    always @(posedge clk) begin
        int n;
        bit acc;
        if (!rst_n) begin
            q.delete();
            exp_mis = 0;
            started = 1;
        end else if (started) begin
            n   = q.size();
            acc = in_valid && (n < DEPTH);
            if (n > 0 && (q[0].nib != 4'h8 || io_ready))
                void'(q.pop_front());
            exp_mis = acc && !is_legal(in_addr, in_funct3);
            if (acc && is_legal(in_addr, in_funct3))
                q.push_back(make_store(in_addr, in_data, in_funct3));
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        st_t        h;
        logic [3:0] e_dm, e_im, e_strb;
        bit         e_io, e_mapped;
        if (started) begin
            e_dm = '0; e_im = '0; e_strb = '0; e_io = 0; e_mapped = 0;
            h.nib = '0; h.addr = '0; h.data = '0; h.strb = '0;
            if (q.size() > 0) begin
                h = q[0];
                if (h.nib == 4'h1 || h.nib == 4'h3) e_dm = h.strb;
                if (h.nib == 4'h2 || h.nib == 4'h3) e_im = h.strb;
                if (h.nib == 4'h8) begin e_io = 1; e_strb = h.strb; end
                e_mapped = (e_dm != 0) || (e_im != 0) || e_io;
            end
            check("empty", 32'(empty), 32'(q.size() == 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            check("misalign_err", 32'(misalign_err), 32'(exp_mis));
            check("dmem_we", 32'(dmem_we), 32'(e_dm));
            check("imem_we", 32'(imem_we), 32'(e_im));
            check("io_valid", 32'(io_valid), 32'(e_io));
            check("io_wstrb", 32'(io_wstrb), 32'(e_strb));
            if (q.size() == 0) begin
                check("idle mem_addr", 32'(mem_addr), 32'h0);
                check("idle mem_wdata", mem_wdata, 32'h0);
                check("idle io_addr", io_addr, 32'h0);
            end else begin
                if (e_mapped) check("mem_wdata", mem_wdata, h.data);
                if (e_dm != 0 || e_im != 0)
                    check("mem_addr", 32'(mem_addr), 32'(h.addr[MEM_AW+1:2]));
                if (e_io) check("io_addr", io_addr, {h.addr[31:2], 2'b00});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        in_valid  = 1'b1;
        in_addr   = a;
        in_data   = d;
        in_funct3 = f3;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_funct3 = '0;
        io_ready  = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst empty", 32'(empty), 32'h1);
        check("rst in_ready", 32'(in_ready), 32'h1);
        check("rst dmem_we", 32'(dmem_we), 32'h0);
        check("rst io_valid", 32'(io_valid), 32'h0);
        check("rst misalign", 32'(misalign_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // SB to DMEM, top byte lane
        put(32'h1000_0003, 32'h0000_00A5, 3'd0);
        check("sb dmem_we", 32'(dmem_we), 32'h8);
        check("sb imem_we", 32'(imem_we), 32'h0);
        check("sb mem_addr", 32'(mem_addr), 32'h0);
        check("sb mem_wdata", mem_wdata, 32'hA5A5_A5A5);

        // SH to DMEM+IMEM, upper half
        put(32'h3000_0012, 32'h1234_BEEF, 3'd1);
        check("sh dmem_we", 32'(dmem_we), 32'hC);
        check("sh imem_we", 32'(imem_we), 32'hC);
        check("sh mem_addr", 32'(mem_addr), 32'h4);
        check("sh wdata hi", 32'(mem_wdata[31:16]), 32'hBEEF);

        // Misaligned SW: rejected, one-cycle pulse
        put(32'h1000_0002, 32'hDEAD_BEEF, 3'd2);
        check("mis pulse", 32'(misalign_err), 32'h1);
        check("mis dmem_we", 32'(dmem_we), 32'h0);
        check("mis empty", 32'(empty), 32'h1);
        @(negedge clk);
        check("mis pulse end", 32'(misalign_err), 32'h0);

        // Stalled IO head followed by DMEM stores
        io_ready = 1'b0;
        put(32'h8000_0008, 32'h1111_1111, 3'd2);
        put(32'h1000_0100, 32'h2222_2222, 3'd2);
        put(32'h1000_0104, 32'h3333_3333, 3'd2);
        put(32'h1000_0108, 32'h4444_4444, 3'd2);
        check("full in_ready", 32'(in_ready), 32'h0);
        check("stall io_valid", 32'(io_valid), 32'h1);
        check("stall io_addr", io_addr, 32'h8000_0008);
        check("stall io_wdata", mem_wdata, 32'h1111_1111);
        in_valid  = 1'b1;
        in_addr   = 32'h1000_010C;
        in_data   = 32'h5555_5555;
        in_funct3 = 3'd2;
        @(negedge clk);
        check("held io_valid", 32'(io_valid), 32'h1);
        check("held io_addr", io_addr, 32'h8000_0008);
        check("held dmem_we", 32'(dmem_we), 32'h0);
        io_ready = 1'b1;
        @(negedge clk);
        io_ready = 1'b0;
        check("drain0 dmem_we", 32'(dmem_we), 32'hF);
        check("drain0 addr", 32'(mem_addr), 32'h40);
        check("drain0 io_valid", 32'(io_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain1 addr", 32'(mem_addr), 32'h41);
        @(negedge clk);
        check("drain2 addr", 32'(mem_addr), 32'h42);
        @(negedge clk);
        check("drain3 addr", 32'(mem_addr), 32'h43);
        check("drain3 wdata", mem_wdata, 32'h5555_5555);
        @(negedge clk);
        check("drained empty", 32'(empty), 32'h1);

        // Fill to full, then reset mid-drain
        put(32'h8000_0000, 32'hAAAA_AAAA, 3'd2);
        put(32'h1000_0200, 32'hBBBB_BBBB, 3'd2);
        put(32'h2000_0204, 32'hCCCC_CCCC, 3'd2);
        put(32'h3000_0208, 32'hDDDD_DDDD, 3'd2);
        check("fill in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        io_ready = 1'b1;
        check("rst2 empty", 32'(empty), 32'h1);
        check("rst2 in_ready", 32'(in_ready), 32'h1);
        check("rst2 io_valid", 32'(io_valid), 32'h0);
        check("rst2 dmem_we", 32'(dmem_we), 32'h0);
        check("rst2 imem_we", 32'(imem_we), 32'h0);
        check("rst2 io_addr", io_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post-rst no write", 32'({dmem_we, imem_we, io_valid}), 32'h0);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            case ($urandom_range(0, 5))
                0:       a[31:28] = 4'h1;
                1:       a[31:28] = 4'h2;
                2:       a[31:28] = 4'h3;
                3:       a[31:28] = 4'h8;
                4:       a[31:28] = 4'h0;
                default: a[31:28] = 4'h5;
            endcase
            a[27:0] = 28'($urandom);
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            in_addr   = a;
            in_data   = $urandom;
            in_funct3 = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2))
                                                   : 3'($urandom_range(3, 7));
            in_valid  = ($urandom_range(0, 9) < 7);
            io_ready  = ($urandom_range(0, 9) < 6);
            rst_n     = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        io_ready = 1'b1;
        rst_n    = 1'b1;
        repeat (DEPTH + 2) @(negedge clk);
        check("final empty", 32'(empty), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
